updi_phy_sequencer: RTL

Sequences the single-wire, half-duplex UPDI PHY on behalf of the data-link layer. Accepts one byte-level command at a time (transmit, receive, or BREAK) and drives the UART TX/RX byte engines and the line direction. Inserts the UPDI guard time on an RX-to-TX turnaround and times out absent targets. Returns exactly one response per command.

---
 rtl/updi_phy_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/updi_phy_sequencer.sv
// UPDI single-wire PHY sequencer: one TX/RX/BREAK command in, exactly one response out.
// Optional echo check of transmitted bytes: define UPDI_PHY_SEQ_ECHO_CHECK_EN.
module updi_phy_sequencer #(
  parameter int BREAK_BITS      = 24,
  parameter int RX_TIMEOUT_BITS = 4096,
  parameter int TMO_W           = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_tick,
  input  logic [2:0] guard_sel,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       rx_en,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       line_oe,
  output logic       line_drive_low
);

  typedef enum logic [2:0] {
    IDLE, GUARD, TX_SEND, TX_WAIT, RX_WAIT, BREAK, RESP
  } state_t;

  localparam logic [TMO_W-1:0] BREAK_LAST = TMO_W'(BREAK_BITS - 1);
  localparam logic [TMO_W-1:0] RX_LAST    = TMO_W'(RX_TIMEOUT_BITS - 1);

  state_t           state;
  logic [TMO_W-1:0] cnt;
  logic             last_rx;
  logic [7:0]       data_q;
  logic [7:0]       guard_q;

  function automatic logic [7:0] guard_bits(input logic [2:0] sel);
    case (sel)
      3'd0:    return 8'd128;
      3'd1:    return 8'd64;
      3'd2:    return 8'd32;
      3'd3:    return 8'd16;
      3'd4:    return 8'd8;
      3'd5:    return 8'd4;
      default: return 8'd2;
    endcase
  endfunction

  // TX response: the echo seen on the shared wire, or the latched byte when not checking.
  logic [7:0] tx_rsp_data;
  logic       tx_rsp_err;
`ifdef UPDI_PHY_SEQ_ECHO_CHECK_EN
  logic       echo_got;
  logic [7:0] echo_byte;
  logic       echo_err;
  logic       e_got;
  logic [7:0] e_byte;
  logic       e_err;

  always_comb begin
    e_got       = echo_got | rx_valid;
    e_byte      = echo_got ? echo_byte : rx_data;
    e_err       = echo_got ? echo_err : rx_err;
    tx_rsp_data = e_got ? e_byte : 8'h00;
    tx_rsp_err  = !e_got || (e_byte != data_q) || e_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_got  <= 1'b0;
      echo_byte <= 8'h00;
      echo_err  <= 1'b0;
    end else if (state == IDLE) begin
      echo_got  <= 1'b0;
      echo_byte <= 8'h00;
      echo_err  <= 1'b0;
    end else if ((state == TX_SEND || state == TX_WAIT) && rx_valid && !echo_got) begin
      echo_got  <= 1'b1;
      echo_byte <= rx_data;
      echo_err  <= rx_err;
    end
  end
  localparam logic TX_RX_EN = 1'b1;
`else
  always_comb begin
    tx_rsp_data = data_q;
    tx_rsp_err  = 1'b0;
  end
  localparam logic TX_RX_EN = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      last_rx        <= 1'b0;
      data_q         <= 8'h00;
      guard_q        <= 8'h00;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 8'h00;
      rsp_err        <= 1'b0;
      tx_valid       <= 1'b0;
      tx_data        <= 8'h00;
      rx_en          <= 1'b0;
      line_oe        <= 1'b0;
      line_drive_low <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            data_q    <= cmd_data;
            guard_q   <= guard_bits(guard_sel);
            cnt       <= '0;
            case (cmd_op)
              2'b00: begin
                if (last_rx) begin
                  state <= GUARD;
                end else begin
                  state    <= TX_SEND;
                  tx_valid <= 1'b1;
                  tx_data  <= cmd_data;
                  line_oe  <= 1'b1;
                  rx_en    <= TX_RX_EN;
                end
              end
              2'b01: begin
                state <= RX_WAIT;
                rx_en <= 1'b1;
              end
              2'b10: begin
                state          <= BREAK;
                line_oe        <= 1'b1;
                line_drive_low <= 1'b1;
                last_rx        <= 1'b0;
              end
              default: begin
                state    <= RESP;
                rsp_data <= 8'h00;
                rsp_err  <= 1'b1;
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        GUARD: begin
          if (bit_tick) begin
            if (cnt == TMO_W'(guard_q - 8'd1)) begin
              state    <= TX_SEND;
              cnt      <= '0;
              last_rx  <= 1'b0;
              tx_valid <= 1'b1;
              tx_data  <= data_q;
              line_oe  <= 1'b1;
              rx_en    <= TX_RX_EN;
            end else begin
              cnt <= cnt + TMO_W'(1);
            end
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            state    <= TX_WAIT;
            tx_valid <= 1'b0;
          end
        end
        TX_WAIT: begin
          if (tx_done) begin
            state    <= RESP;
            line_oe  <= 1'b0;
            rx_en    <= 1'b0;
            rsp_data <= tx_rsp_data;
            rsp_err  <= tx_rsp_err;
          end
        end
        RX_WAIT: begin
          // A byte landing on the final timeout tick is still delivered.
          if (rx_valid) begin
            state    <= RESP;
            rx_en    <= 1'b0;
            rsp_data <= rx_data;
            rsp_err  <= rx_err;
            last_rx  <= 1'b1;
          end else if (bit_tick) begin
            if (cnt == RX_LAST) begin
              state    <= RESP;
              rx_en    <= 1'b0;
              rsp_data <= 8'h00;
              rsp_err  <= 1'b1;
            end else begin
              cnt <= cnt + TMO_W'(1);
            end
          end
        end
        BREAK: begin
          if (bit_tick) begin
            if (cnt == BREAK_LAST) begin
              state          <= RESP;
              line_oe        <= 1'b0;
              line_drive_low <= 1'b0;
              rsp_data       <= 8'h00;
              rsp_err        <= 1'b0;
            end else begin
              cnt <= cnt + TMO_W'(1);
            end
          end
        end
        RESP: begin
          // First RESP cycle raises rsp_valid, second returns to IDLE.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
